// File: rtl/execute_mdu.sv
// Iterative RISC-V M-extension unit: shift-add multiply and restoring divide at one
// bit per cycle, with single-cycle paths for divide-by-zero, signed overflow and MULHW-class.
module execute_mdu #(
  parameter int XLEN = 64,
  parameter bit W_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mdu_i_valid,
  output logic            mdu_o_ready,
  input  logic [2:0]      mdu_i_op,
  input  logic            mdu_i_w_instr,
  input  logic [XLEN-1:0] mdu_i_valA,
  input  logic [XLEN-1:0] mdu_i_valB,
  input  logic            mdu_i_flush,
  output logic            mdu_o_valid,
  input  logic            mdu_i_ready,
  output logic [XLEN-1:0] mdu_o_valE,
  output logic            mdu_o_busy,
  output logic [1:0]      mdu_o_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never waits on ready, and the result is held stable while unaccepted.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int CW   = $clog2(XLEN) + 1;
  localparam bit W_OK = (XLEN == 64) && W_EN;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = '0;
    r[31:0] = v;
    return r;
  endfunction

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic                w_q, w_d;
  logic                neg_q, neg_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [XLEN-1:0]     res_q, res_d;

  // Request decode, evaluated on the raw inputs while idle.
  logic            w_eff, is_div, sgn_a, sgn_b, a_neg, b_neg;
  logic            div_zero, div_ovf, mulh_w, special;
  logic [XLEN-1:0] ext_a, ext_b, mag_a, mag_b, min_neg, dvd_res, spec_res;

  always_comb begin
    w_eff   = W_OK && mdu_i_w_instr;
    is_div  = mdu_i_op[2];
    sgn_a   = (mdu_i_op == 3'd1) || (mdu_i_op == 3'd2) || (mdu_i_op == 3'd4) || (mdu_i_op == 3'd6);
    sgn_b   = (mdu_i_op == 3'd1) || (mdu_i_op == 3'd4) || (mdu_i_op == 3'd6);
    if (w_eff) begin
      ext_a   = sgn_a ? sext32(mdu_i_valA[31:0]) : zext32(mdu_i_valA[31:0]);
      ext_b   = sgn_b ? sext32(mdu_i_valB[31:0]) : zext32(mdu_i_valB[31:0]);
      min_neg = sext32(32'h8000_0000);
      dvd_res = sext32(mdu_i_valA[31:0]);
    end else begin
      ext_a   = mdu_i_valA;
      ext_b   = mdu_i_valB;
      min_neg = {1'b1, {(XLEN-1){1'b0}}};
      dvd_res = mdu_i_valA;
    end
    a_neg    = sgn_a && ext_a[XLEN-1];
    b_neg    = sgn_b && ext_b[XLEN-1];
    mag_a    = a_neg ? -ext_a : ext_a;
    mag_b    = b_neg ? -ext_b : ext_b;
    div_zero = is_div && (ext_b == '0);
    div_ovf  = is_div && !mdu_i_op[0] && (ext_a == min_neg) && (ext_b == '1);
    mulh_w   = w_eff && !mdu_i_op[2] && (mdu_i_op[1:0] != 2'd0);
    special  = mulh_w || div_zero || div_ovf;
    spec_res = '0;
    if (mulh_w)        spec_res = '0;
    else if (div_zero) spec_res = mdu_i_op[1] ? dvd_res : '1;
    else if (div_ovf)  spec_res = mdu_i_op[1] ? '0 : dvd_res;
  end

  // One iteration: acc holds {hi, lo}; multiply shifts right, divide shifts left.
  logic [XLEN:0]     add_sum, rem_sh, sub_diff;
  logic [2*XLEN-1:0] acc_step;

  always_comb begin
    add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    sub_diff = rem_sh - {1'b0, opnd_q};
    if (op_q[2]) begin
      if (!sub_diff[XLEN]) acc_step = {sub_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else                 acc_step = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else if (acc_q[0]) begin
      acc_step = {add_sum, acc_q[XLEN-1:1]};
    end else begin
      acc_step = {1'b0, acc_q[2*XLEN-1:1]};
    end
  end

  // Final result from the last iteration; a 32-step multiply leaves its low word at [XLEN-1 -: 32].
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   dv, dv_s, fin_res;

  always_comb begin
    prod_s = neg_q ? -acc_step : acc_step;
    dv     = op_q[1] ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
    dv_s   = neg_q ? -dv : dv;
    if (!op_q[2]) begin
      if (w_q)                     fin_res = sext32(acc_step[XLEN-1 -: 32]);
      else if (op_q[1:0] == 2'd0)  fin_res = prod_s[XLEN-1:0];
      else                         fin_res = prod_s[2*XLEN-1:XLEN];
    end else begin
      fin_res = w_q ? sext32(dv_s[31:0]) : dv_s;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    w_d     = w_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    mdu_o_ready = (state_q == S_IDLE) && !mdu_i_flush;
    mdu_o_valid = (state_q == S_DONE) && !mdu_i_flush;
    mdu_o_busy  = (state_q == S_CALC);
    if (mdu_i_flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mdu_i_valid) begin
            op_d  = mdu_i_op;
            w_d   = w_eff;
            neg_d = (is_div && mdu_i_op[1]) ? a_neg : (a_neg ^ b_neg);
            if (special) begin
              res_d   = spec_res;
              state_d = S_DONE;
            end else begin
              if (is_div) begin
                acc_d  = {{XLEN{1'b0}}, (w_eff ? (mag_a << (XLEN - 32)) : mag_a)};
                opnd_d = mag_b;
              end else begin
                acc_d  = {{XLEN{1'b0}}, mag_b};
                opnd_d = mag_a;
              end
              cnt_d   = w_eff ? CW'(31) : CW'(XLEN - 1);
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_d = acc_step;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            res_d   = fin_res;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (mdu_i_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      w_q     <= 1'b0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      w_q     <= w_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
    end
  end

  assign mdu_o_valE  = res_q;
  assign mdu_o_state = state_q;

endmodule

// File: tb/tb_execute_mdu.sv
// Bench for execute_mdu (XLEN=64): directed scenarios plus random ops against a
// plain-arithmetic reference model, with latency, stall, flush and reset checks.
module tb_execute_mdu;

  logic        clk;
  logic        rst_n;
  logic        mdu_i_valid;
  logic        mdu_o_ready;
  logic [2:0]  mdu_i_op;
  logic        mdu_i_w_instr;
  logic [63:0] mdu_i_valA;
  logic [63:0] mdu_i_valB;
  logic        mdu_i_flush;
  logic        mdu_o_valid;
  logic        mdu_i_ready;
  logic [63:0] mdu_o_valE;
  logic        mdu_o_busy;
  logic [1:0]  mdu_o_state;

  int total;
  int bad;

  logic [63:0] exp_q[$];
  logic [63:0] hs_val_q[$];
  int          acc_cyc_q[$];
  int          cyc;
  int          acc_cnt;
  int          hs_cnt;

  execute_mdu #(.XLEN(64), .W_EN(1'b1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mdu_i_valid   (mdu_i_valid),
    .mdu_o_ready   (mdu_o_ready),
    .mdu_i_op      (mdu_i_op),
    .mdu_i_w_instr (mdu_i_w_instr),
    .mdu_i_valA    (mdu_i_valA),
    .mdu_i_valB    (mdu_i_valB),
    .mdu_i_flush   (mdu_i_flush),
    .mdu_o_valid   (mdu_o_valid),
    .mdu_i_ready   (mdu_i_ready),
    .mdu_o_valE    (mdu_o_valE),
    .mdu_o_busy    (mdu_o_busy),
    .mdu_o_state   (mdu_o_state)
  );

  // ---------------- clock / monitor ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (rst_n && mdu_i_valid && mdu_o_ready) begin
      acc_cnt++;
      acc_cyc_q.push_back(cyc);
    end
    if (rst_n && mdu_o_valid && mdu_i_ready) begin
      hs_cnt++;
      hs_val_q.push_back(mdu_o_valE);
    end
    cyc++;
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [127:0]       p;
    logic signed [63:0] sa, sb;
    logic signed [31:0] sa32, sb32;
    logic [31:0]        ua32, ub32, r32;
    logic               ovf;
    logic [63:0]        r;
    sa = a; sb = b; ua32 = a[31:0]; ub32 = b[31:0]; sa32 = a[31:0]; sb32 = b[31:0];
    r = '0; r32 = '0; p = '0;
    if (w) begin
      ovf = (ua32 == 32'h8000_0000) && (ub32 == 32'hFFFF_FFFF);
      case (op)
        3'd0: r32 = ua32 * ub32;
        3'd4: if (ub32 == 0) r32 = '1; else if (ovf) r32 = ua32; else r32 = sa32 / sb32;
        3'd5: r32 = (ub32 == 0) ? 32'hFFFF_FFFF : ua32 / ub32;
        3'd6: if (ub32 == 0) r32 = ua32; else if (ovf) r32 = '0; else r32 = sa32 % sb32;
        3'd7: r32 = (ub32 == 0) ? ua32 : ua32 % ub32;
        default: r32 = '0;
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      ovf = (a == 64'h8000_0000_0000_0000) && (b == '1);
      case (op)
        3'd0: r = a * b;
        3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
        3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b};       r = p[127:64]; end
        3'd3: begin p = {64'd0, a} * {64'd0, b};             r = p[127:64]; end
        3'd4: if (b == 0) r = '1; else if (ovf) r = a; else r = sa / sb;
        3'd5: r = (b == 0) ? '1 : a / b;
        3'd6: if (b == 0) r = a; else if (ovf) r = '0; else r = sa % sb;
        default: r = (b == 0) ? a : a % b;
      endcase
    end
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    logic special;
    if (w) special = (op inside {3'd1, 3'd2, 3'd3}) ||
                     (op[2] && b[31:0] == 0) ||
                     ((op == 3'd4 || op == 3'd6) && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    else   special = (op[2] && b == 0) ||
                     ((op == 3'd4 || op == 3'd6) && a == 64'h8000_0000_0000_0000 && b == '1);
    return special ? 1 : (w ? 33 : 65);
  endfunction

  function automatic logic [63:0] pick_val();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = 64'd0;
      1: v = 64'd1;
      2: v = '1;
      3: v = 64'h8000_0000_0000_0000;
      4: v = {$urandom, 32'h8000_0000};
      5: v = {$urandom, 32'hFFFF_FFFF};
      6: v = 64'($urandom_range(0, 100));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // ---------------- driver ----------------
  // Issues one request, returns the first valid result and its latency
  // (accept edge counts as 1); performs the handshake if mdu_i_ready is high.
  task automatic run_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, output logic [63:0] res, output int lat);
    int a0;
    int guard;
    a0 = acc_cnt;
    guard = 0;
    mdu_i_op = op; mdu_i_w_instr = w; mdu_i_valA = a; mdu_i_valB = b;
    mdu_i_valid = 1'b1;
    while (acc_cnt == a0 && guard < 300) begin @(posedge clk); #1; guard++; end
    mdu_i_valid = 1'b0;
    lat = 1;
    while (!mdu_o_valid && lat < 300) begin @(posedge clk); #1; lat++; end
    res = mdu_o_valE;
    if (mdu_i_ready) begin @(posedge clk); #1; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (mdu_o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", mdu_o_valid); end
    total++; if (mdu_o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", mdu_o_busy); end
    total++; if (mdu_o_valE !== 64'd0) begin bad++; $display("FAIL reset_valE: got %h want 0", mdu_o_valE); end
    total++; if (mdu_o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", mdu_o_ready); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [63:0] r;
    int lat;
    run_op(3'd0, 1'b0, 64'd7, -64'sd3, r, lat);
    total++; if (r !== 64'hFFFF_FFFF_FFFF_FFEB) begin bad++; $display("FAIL mul_7x-3: got %h want ffffffffffffffeb", r); end
    total++; if (lat !== 65) begin bad++; $display("FAIL mul_latency: got %0d want 65", lat); end
    run_op(3'd3, 1'b0, '1, 64'd2, r, lat);
    total++; if (r !== 64'd1) begin bad++; $display("FAIL mulhu: got %h want 1", r); end
    run_op(3'd1, 1'b0, '1, 64'd2, r, lat);
    total++; if (r !== '1) begin bad++; $display("FAIL mulh: got %h want ffffffffffffffff", r); end
    run_op(3'd2, 1'b0, '1, 64'd2, r, lat);
    total++; if (r !== '1) begin bad++; $display("FAIL mulhsu: got %h want ffffffffffffffff", r); end
  endtask

  task automatic test_div();
    logic [63:0] r;
    int lat;
    run_op(3'd4, 1'b0, -64'sd7, 64'd2, r, lat);
    total++; if (r !== -64'sd3) begin bad++; $display("FAIL div_-7/2: got %h want %h", r, -64'sd3); end
    run_op(3'd6, 1'b0, -64'sd7, 64'd2, r, lat);
    total++; if (r !== -64'sd1) begin bad++; $display("FAIL rem_-7%%2: got %h want %h", r, -64'sd1); end
    run_op(3'd5, 1'b0, 64'd1234, 64'd0, r, lat);
    total++; if (r !== '1) begin bad++; $display("FAIL divu_by0: got %h want all ones", r); end
    total++; if (lat !== 1) begin bad++; $display("FAIL divu_by0_latency: got %0d want 1", lat); end
    run_op(3'd7, 1'b0, 64'd1234, 64'd0, r, lat);
    total++; if (r !== 64'd1234) begin bad++; $display("FAIL remu_by0: got %h want 4d2", r); end
    run_op(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, r, lat);
    total++; if (r !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL div_ovf: got %h want 8000000000000000", r); end
    total++; if (lat !== 1) begin bad++; $display("FAIL div_ovf_latency: got %0d want 1", lat); end
    run_op(3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, r, lat);
    total++; if (r !== 64'd0) begin bad++; $display("FAIL rem_ovf: got %h want 0", r); end
  endtask

  task automatic test_w_ops();
    logic [63:0] r;
    int lat;
    run_op(3'd5, 1'b1, 64'h0000_0000_8000_0000, 64'd1, r, lat);
    total++; if (r !== 64'hFFFF_FFFF_8000_0000) begin bad++; $display("FAIL divuw: got %h want ffffffff80000000", r); end
    total++; if (lat !== 33) begin bad++; $display("FAIL divuw_latency: got %0d want 33", lat); end
    run_op(3'd0, 1'b1, 64'h10000, 64'h10000, r, lat);
    total++; if (r !== 64'd0) begin bad++; $display("FAIL mulw: got %h want 0", r); end
    run_op(3'd1, 1'b1, 64'h1234_5678, 64'h9abc_def0, r, lat);
    total++; if (r !== 64'd0) begin bad++; $display("FAIL mulhw_class: got %h want 0", r); end
    total++; if (lat !== 1) begin bad++; $display("FAIL mulhw_latency: got %0d want 1", lat); end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic        w;
    logic [63:0] a, b, r, e;
    int lat, elat;
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      w  = ($urandom_range(0, 2) == 0);
      a  = pick_val();
      b  = pick_val();
      exp_q.push_back(ref_res(op, w, a, b));
      elat = ref_lat(op, w, a, b);
      run_op(op, w, a, b, r, lat);
      e = exp_q.pop_front();
      total++; if (r !== e) begin bad++; $display("FAIL rand_%0d op=%0d w=%0b a=%h b=%h: got %h want %h", i, op, w, a, b, r, e); end
      total++; if (lat !== elat) begin bad++; $display("FAIL rand_lat_%0d: got %0d want %0d", i, lat, elat); end
    end
  endtask

  task automatic test_ready_hold();
    logic [63:0] r, e;
    int lat, h0;
    mdu_i_ready = 1'b0;
    e = ref_res(3'd0, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_1001);
    run_op(3'd0, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_1001, r, lat);
    h0 = hs_cnt;
    for (int k = 0; k < 5; k++) begin
      total++; if (mdu_o_valE !== e) begin bad++; $display("FAIL hold_valE_%0d: got %h want %h", k, mdu_o_valE, e); end
      total++; if (mdu_o_ready !== 1'b0 || mdu_o_valid !== 1'b1) begin
        bad++; $display("FAIL hold_flags_%0d: got ready=%b valid=%b want ready=0 valid=1", k, mdu_o_ready, mdu_o_valid);
      end
      @(posedge clk); #1;
    end
    mdu_i_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (hs_cnt !== h0 + 1) begin bad++; $display("FAIL hold_handshake: got %0d want %0d", hs_cnt, h0 + 1); end
    total++; if (mdu_o_valid !== 1'b0) begin bad++; $display("FAIL hold_after_valid: got %b want 0", mdu_o_valid); end
  endtask

  task automatic test_flush();
    logic [63:0] r;
    int lat, a0, h0, guard, vis;
    a0 = acc_cnt; h0 = hs_cnt; guard = 0;
    mdu_i_op = 3'd4; mdu_i_w_instr = 1'b0; mdu_i_valA = 64'd1000; mdu_i_valB = 64'd7;
    mdu_i_valid = 1'b1;
    while (acc_cnt == a0 && guard < 50) begin @(posedge clk); #1; guard++; end
    mdu_i_valid = 1'b0;
    for (int k = 1; k < 10; k++) begin @(posedge clk); #1; end
    total++; if (mdu_o_busy !== 1'b1) begin bad++; $display("FAIL flush_pre_busy: got %b want 1", mdu_o_busy); end
    mdu_i_flush = 1'b1;
    mdu_i_valid = 1'b1;
    #1;
    total++; if (mdu_o_ready !== 1'b0) begin bad++; $display("FAIL flush_ready: got %b want 0", mdu_o_ready); end
    @(posedge clk); #1;
    mdu_i_flush = 1'b0;
    mdu_i_valid = 1'b0;
    #1;
    total++; if (mdu_o_busy !== 1'b0 || mdu_o_valid !== 1'b0 || mdu_o_ready !== 1'b1) begin
      bad++; $display("FAIL flush_idle: got busy=%b valid=%b ready=%b want 0 0 1", mdu_o_busy, mdu_o_valid, mdu_o_ready);
    end
    total++; if (acc_cnt !== a0 + 1) begin bad++; $display("FAIL flush_wins: got accepts=%0d want %0d", acc_cnt, a0 + 1); end
    vis = 0;
    for (int k = 0; k < 70; k++) begin @(posedge clk); #1; if (mdu_o_valid) vis++; end
    total++; if (vis !== 0 || hs_cnt !== h0) begin bad++; $display("FAIL flush_stale: got valid_cycles=%0d hs=%0d want 0 %0d", vis, hs_cnt, h0); end
    // flush while holding a result
    mdu_i_ready = 1'b0;
    run_op(3'd5, 1'b0, 64'd99, 64'd0, r, lat);
    mdu_i_flush = 1'b1;
    mdu_i_ready = 1'b1;
    #1;
    total++; if (mdu_o_valid !== 1'b0) begin bad++; $display("FAIL flush_done_valid: got %b want 0", mdu_o_valid); end
    @(posedge clk); #1;
    mdu_i_flush = 1'b0;
    #1;
    total++; if (hs_cnt !== h0 || mdu_o_ready !== 1'b1) begin bad++; $display("FAIL flush_done_idle: got hs=%0d ready=%b want %0d 1", hs_cnt, mdu_o_ready, h0); end
  endtask

  task automatic test_reset_mid_calc();
    logic [63:0] r, e;
    int lat, a0, guard, vis;
    a0 = acc_cnt; guard = 0;
    mdu_i_op = 3'd0; mdu_i_w_instr = 1'b0; mdu_i_valA = 64'hDEAD_BEEF; mdu_i_valB = 64'h1234;
    mdu_i_valid = 1'b1;
    while (acc_cnt == a0 && guard < 50) begin @(posedge clk); #1; guard++; end
    mdu_i_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    total++; if (mdu_o_valid !== 1'b0 || mdu_o_busy !== 1'b0 || mdu_o_valE !== 64'd0) begin
      bad++; $display("FAIL rst_mid: got valid=%b busy=%b valE=%h want 0 0 0", mdu_o_valid, mdu_o_busy, mdu_o_valE);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    vis = 0;
    for (int k = 0; k < 70; k++) begin @(posedge clk); #1; if (mdu_o_valid || mdu_o_busy) vis++; end
    total++; if (vis !== 0) begin bad++; $display("FAIL rst_stale: got active_cycles=%0d want 0", vis); end
    e = ref_res(3'd6, 1'b0, -64'sd100, 64'd7);
    run_op(3'd6, 1'b0, -64'sd100, 64'd7, r, lat);
    total++; if (r !== e) begin bad++; $display("FAIL rst_fresh_op: got %h want %h", r, e); end
    total++; if (lat !== 65) begin bad++; $display("FAIL rst_fresh_latency: got %0d want 65", lat); end
  endtask

  task automatic test_back_to_back();
    int a0, h0, guard, gap;
    logic [63:0] got, e;
    acc_cyc_q.delete();
    hs_val_q.delete();
    a0 = acc_cnt; h0 = hs_cnt; guard = 0;
    mdu_i_ready = 1'b1;
    mdu_i_op = 3'd0; mdu_i_w_instr = 1'b0;
    mdu_i_valA = 64'h1234_5678_9ABC_DEF0; mdu_i_valB = 64'h0FED_CBA9_8765_4321;
    exp_q.push_back(ref_res(3'd0, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321));
    mdu_i_valid = 1'b1;
    while (acc_cnt == a0 && guard < 50) begin @(posedge clk); #1; guard++; end
    mdu_i_op = 3'd5;
    mdu_i_valA = 64'hFFFF_0000_1111_2222; mdu_i_valB = 64'd12345;
    exp_q.push_back(ref_res(3'd5, 1'b0, 64'hFFFF_0000_1111_2222, 64'd12345));
    guard = 0;
    while (acc_cnt < a0 + 2 && guard < 200) begin @(posedge clk); #1; guard++; end
    mdu_i_valid = 1'b0;
    guard = 0;
    while (hs_cnt < h0 + 2 && guard < 200) begin @(posedge clk); #1; guard++; end
    gap = (acc_cyc_q.size() >= 2) ? acc_cyc_q[1] - acc_cyc_q[0] : -1;
    total++; if (gap !== 66) begin bad++; $display("FAIL b2b_gap: got %0d want 66", gap); end
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      got = (hs_val_q.size() > i) ? hs_val_q[i] : 'x;
      total++; if (got !== e) begin bad++; $display("FAIL b2b_result_%0d: got %h want %h", i, got, e); end
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; acc_cnt = 0; hs_cnt = 0;
    rst_n = 1'b0;
    mdu_i_valid = 1'b0; mdu_i_op = 3'd0; mdu_i_w_instr = 1'b0;
    mdu_i_valA = '0; mdu_i_valB = '0; mdu_i_flush = 1'b0; mdu_i_ready = 1'b1;
    test_reset();
    test_mul();
    test_div();
    test_w_ops();
    test_random();
    test_ready_hold();
    test_flush();
    test_reset_mid_calc();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
